// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared definitions for the tick generator.
//   rate_e       - encodings of the rate_sel input
//   deb_state_e  - debounce FSM state encoding
//   reload_value - divider period (in clock cycles) for a given rate_sel
package tick_gen_pkg;

  typedef enum logic [1:0] {
    RATE_FULL    = 2'b00,
    RATE_1HZ     = 2'b01,
    RATE_HALF    = 2'b10,
    RATE_QUARTER = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } deb_state_e;

  // Period R of the divider for a rate selection. The down-counter reloads with R-1.
  function automatic logic [31:0] reload_value(input logic [1:0] sel,
                                               input int unsigned clk_hz);
    logic [31:0] r;
    case (rate_e'(sel))
      RATE_1HZ:     r = clk_hz;
      RATE_HALF:    r = 2 * clk_hz;
      RATE_QUARTER: r = 4 * clk_hz;
      default:      r = 32'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/debouncer.sv
// debouncer: synchronizes a raw active-low pushbutton and emits exactly one
// single-cycle pulse per accepted press. Presses and releases must both be
// stable for DEBOUNCE_CYCLES synchronized cycles; releases never pulse.
// Ports:
//   i_clk         - system clock
//   i_reset       - synchronous active-high reset
//   i_step_n      - raw, asynchronous, bouncy pushbutton (active low)
//   o_step_pulse  - one-cycle accept strobe, valid in the cycle before the edge that
//                   accepts the press (the parent registers it)
module debouncer
  import tick_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_step_n,
  output logic o_step_pulse
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLast = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  deb_state_e       r_state;
  logic [DW-1:0]    r_d;
  logic             w_s;
  logic             w_d_done;

  assign w_s      = r_sync[1];
  assign w_d_done = (r_d == DLast);

  // Decoded from current state so the parent's registered tick lands on the
  // same edge that moves the FSM into PRESSED.
  assign o_step_pulse = (r_state == PRESS_WAIT) && !w_s && w_d_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_d     <= '0;
    end else begin
      r_sync <= {r_sync[0], i_step_n};
      case (r_state)
        IDLE: begin
          if (!w_s) begin
            r_state <= PRESS_WAIT;
            r_d     <= '0;
          end
        end
        PRESS_WAIT: begin
          if (w_s) begin
            r_state <= IDLE;
          end else if (w_d_done) begin
            r_state <= PRESSED;
          end else begin
            r_d <= r_d + DW'(1);
          end
        end
        PRESSED: begin
          if (w_s) begin
            r_state <= RELEASE_WAIT;
            r_d     <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back low returns to PRESSED without a new pulse.
          if (!w_s) begin
            r_state <= PRESSED;
          end else if (w_d_done) begin
            r_state <= IDLE;
          end else begin
            r_d <= r_d + DW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tick_generator.sv
// tick_generator: pacing stage for the display counter. Merges a programmable
// free-running rate divider with a debounced manual step into one registered
// single-cycle enable pulse, and toggles a heartbeat LED on every tick.
// Ports:
//   i_clk        - system clock
//   i_reset      - synchronous active-high reset
//   i_rate_sel   - 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
//   i_run        - 1 runs the divider, 0 freezes it
//   i_step_n     - raw active-low pushbutton
//   o_tick       - registered enable pulse
//   o_heartbeat  - registered, toggles on every tick
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_rate_sel,
  input  logic       i_run,
  input  logic       i_step_n,
  output logic       o_tick,
  output logic       o_heartbeat
);

  localparam int unsigned CntW = $clog2(4 * CLK_HZ);

  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_rate_q;
  logic            r_tick;
  logic            r_heartbeat;

  logic [CntW-1:0] w_reload;
  logic            w_rate_chg;
  logic            w_cnt_zero;
  logic            w_auto_tick;
  logic            w_step_pulse;
  logic            w_any_tick;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_step_n     (i_step_n),
    .o_step_pulse (w_step_pulse)
  );

  assign w_reload    = CntW'(reload_value(i_rate_sel, CLK_HZ) - 32'd1);
  assign w_rate_chg  = (i_rate_sel != r_rate_q);
  assign w_cnt_zero  = (r_cnt == '0);
  // A rate change restarts the period and suppresses the tick on that edge.
  assign w_auto_tick = !w_rate_chg && i_run && w_cnt_zero;
  // OR-merge: coincident sources yield a single pulse and a single toggle.
  assign w_any_tick  = w_auto_tick | w_step_pulse;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= w_reload;
      r_rate_q    <= i_rate_sel;
      r_tick      <= 1'b0;
      r_heartbeat <= 1'b0;
    end else begin
      r_tick      <= w_any_tick;
      r_heartbeat <= r_heartbeat ^ w_any_tick;
      if (w_rate_chg) begin
        r_cnt    <= w_reload;
        r_rate_q <= i_rate_sel;
      end else if (i_run) begin
        if (w_cnt_zero) begin
          r_cnt <= w_reload;
        end else begin
          r_cnt <= r_cnt - CntW'(1);
        end
      end
    end
  end

  assign o_tick      = r_tick;
  assign o_heartbeat = r_heartbeat;

endmodule

// File: tb/tb_tick_generator.sv
module tb_tick_generator;

  logic       clk;
  logic       reset;
  logic [1:0] rate_sel;
  logic       run;
  logic       step_n;
  logic       tick;
  logic       heartbeat;

  int checks;
  int errors;

  tick_generator #(
    .CLK_HZ          (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rate_sel  (rate_sel),
    .i_run       (run),
    .i_step_n    (step_n),
    .o_tick      (tick),
    .o_heartbeat (heartbeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One reset edge; the next edge is edge 0.
  task automatic do_reset(input logic [1:0] rs, input logic rn);
    rate_sel = rs;
    run      = rn;
    step_n   = 1'b1;
    reset    = 1'b1;
    step_clk();
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    rate_sel = 2'b01;
    run      = 1'b1;
    step_n   = 1'b1;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      checks++;
      if (tick !== 1'b0 || heartbeat !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d tick=%b hb=%b expected 0 0", i, tick, heartbeat);
      end
    end
    reset = 1'b0;
    step_clk();
    checks++;
    if (tick !== 1'b0 || heartbeat !== 1'b0) begin
      errors++;
      $display("FAIL reset_release tick=%b hb=%b expected 0 0", tick, heartbeat);
    end
  endtask

  task automatic test_rate_1hz();
    logic exp_t;
    logic exp_h;
    exp_h = 1'b0;
    do_reset(2'b01, 1'b1);
    for (int e = 0; e <= 30; e++) begin
      step_clk();
      exp_t = (e == 9 || e == 19 || e == 29);
      exp_h = exp_h ^ exp_t;
      checks++;
      if (tick !== exp_t || heartbeat !== exp_h) begin
        errors++;
        $display("FAIL rate_1hz e=%0d tick=%b hb=%b expected %b %b",
                 e, tick, heartbeat, exp_t, exp_h);
      end
    end
  endtask

  task automatic test_rate_change();
    logic exp_t;
    do_reset(2'b11, 1'b1);
    for (int e = 0; e <= 60; e++) begin
      if (e == 45) rate_sel = 2'b01;
      step_clk();
      exp_t = (e == 39 || e == 55);
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL rate_change e=%0d tick=%b expected %b", e, tick, exp_t);
      end
    end
  endtask

  task automatic test_pause();
    logic exp_t;
    do_reset(2'b01, 1'b1);
    for (int e = 0; e <= 37; e++) begin
      if (e == 12) run = 1'b0;
      if (e == 19) run = 1'b1;
      step_clk();
      exp_t = (e == 9 || e == 26 || e == 36);
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL pause e=%0d tick=%b expected %b", e, tick, exp_t);
      end
    end
  endtask

  task automatic test_full_rate();
    logic exp_t;
    logic exp_h;
    do_reset(2'b00, 1'b1);
    for (int e = 0; e <= 11; e++) begin
      if (e == 10) run = 1'b0;
      step_clk();
      exp_t = (e < 10);
      exp_h = (e < 10) ? (e % 2 == 0) : 1'b0;
      checks++;
      if (tick !== exp_t || heartbeat !== exp_h) begin
        errors++;
        $display("FAIL full_rate e=%0d tick=%b hb=%b expected %b %b",
                 e, tick, heartbeat, exp_t, exp_h);
      end
    end
  endtask

  // Press bounce, long press, release bounce, then a second clean press.
  task automatic test_bouncy_step();
    logic exp_t;
    logic low;
    do_reset(2'b01, 1'b0);
    for (int e = 0; e <= 44; e++) begin
      low = (e >= 2 && e <= 3) || (e >= 5 && e <= 16) || (e == 18) ||
            (e >= 32 && e <= 40);
      step_n = !low;
      step_clk();
      exp_t = (e == 11 || e == 38);
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL bouncy_step e=%0d tick=%b expected %b", e, tick, exp_t);
      end
    end
    checks++;
    if (heartbeat !== 1'b0) begin
      errors++;
      $display("FAIL bouncy_step_hb hb=%b expected 0", heartbeat);
    end
  endtask

  // Step accepted at edge 19, the same edge as the second auto tick.
  task automatic test_coincidence();
    logic exp_t;
    logic exp_h;
    exp_h = 1'b0;
    do_reset(2'b01, 1'b1);
    for (int e = 0; e <= 30; e++) begin
      step_n = !(e >= 13 && e <= 25);
      step_clk();
      exp_t = (e == 9 || e == 19 || e == 29);
      exp_h = exp_h ^ exp_t;
      checks++;
      if (tick !== exp_t || heartbeat !== exp_h) begin
        errors++;
        $display("FAIL coincidence e=%0d tick=%b hb=%b expected %b %b",
                 e, tick, heartbeat, exp_t, exp_h);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp_t;
    do_reset(2'b01, 1'b1);
    for (int e = 0; e <= 15; e++) step_clk();
    // cnt is 3 here; heartbeat is 1 from the tick at edge 9.
    reset = 1'b1;
    step_clk();
    checks++;
    if (tick !== 1'b0 || heartbeat !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset tick=%b hb=%b expected 0 0", tick, heartbeat);
    end
    reset = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      step_clk();
      checks++;
      if (tick !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_after e=%0d tick=%b expected 0", e, tick);
      end
    end
    // Reset on the edge that would have ticked: the pending tick is dropped.
    reset = 1'b1;
    step_clk();
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL pending_drop tick=%b expected 0", tick);
    end
    reset = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      step_clk();
      exp_t = (e == 9);
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL reset_restart e=%0d tick=%b expected %b", e, tick, exp_t);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    rate_sel = 2'b01;
    run      = 1'b0;
    step_n   = 1'b1;
    test_reset();
    test_rate_1hz();
    test_rate_change();
    test_pause();
    test_full_rate();
    test_bouncy_step();
    test_coincidence();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
